// File: rtl/uart_rx_frame_ctrl.sv
// UART receive controller: frame FSM, oversampled 3-point majority bit recovery,
// run-time frame format (5-8 data bits, parity, 1/2 stop bits), break detection.
module uart_rx_frame_ctrl #(
  parameter int MAX_DATA_WIDTH = 8,
  parameter int PRESCALE_BITS  = 6,
  parameter int BIT_CNT_BITS   = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_BITS-1:0]  Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [1:0]                DATA_LEN,
  input  logic                      STP2,
  output logic [MAX_DATA_WIDTH-1:0] P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR,
  output logic                      BRK_DET,
  output logic                      BUSY
);

  // DATA_VALID is a one-cycle strobe with no ready: the consumer must take
  // P_DATA in that cycle; P_DATA then holds until the next good frame.

  typedef enum logic [2:0] {
    S_LINE_WAIT, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CHECK
  } state_t;

  localparam logic [PRESCALE_BITS-1:0] ONE_P = PRESCALE_BITS'(1);
  localparam logic [BIT_CNT_BITS-1:0]  ONE_B = BIT_CNT_BITS'(1);

  state_t                     state, next_state;
  logic [PRESCALE_BITS-1:0]   edge_cnt, half, cfg_p;
  logic [BIT_CNT_BITS-1:0]    bit_cnt, n_bits;
  logic [1:0]                 samp, cfg_dlen;
  logic                       bit_q, cfg_par_en, cfg_par_typ, cfg_stp2;
  logic [MAX_DATA_WIDTH-1:0]  shift_r, data_rj;
  logic                       par_q, stop1_q, stop_bad_q;
  logic                       in_bit, at_m_lo, at_m, at_m_hi, end_bit;
  logic                       maj_now, bit_now, last_data, last_stop;
  logic                       stop1_f, stop_bad_f, brk_f, par_bad_f, ok_f, enter_start;

  always_comb begin
    in_bit      = state inside {S_START, S_DATA, S_PARITY, S_STOP};
    half        = cfg_p >> 1;
    at_m_lo     = (edge_cnt == half - ONE_P);
    at_m        = (edge_cnt == half);
    at_m_hi     = (edge_cnt == half + ONE_P);
    end_bit     = (edge_cnt == cfg_p - ONE_P);
    maj_now     = (samp[1] & samp[0]) | ((samp[1] | samp[0]) & RX_IN);
    // When the third sample lands on the last edge, the stored bit is not ready yet.
    bit_now     = at_m_hi ? maj_now : bit_q;
    n_bits      = BIT_CNT_BITS'(5) + BIT_CNT_BITS'(cfg_dlen);
    last_data   = (bit_cnt == n_bits - ONE_B);
    last_stop   = (bit_cnt == BIT_CNT_BITS'(cfg_stp2));
    data_rj     = shift_r >> (BIT_CNT_BITS'(MAX_DATA_WIDTH) - n_bits);
    stop1_f     = (bit_cnt == '0) ? bit_now : stop1_q;
    stop_bad_f  = stop_bad_q | ~bit_now;
    brk_f       = (data_rj == '0) && !(cfg_par_en && par_q) && !stop1_f;
    par_bad_f   = cfg_par_en && ((^data_rj ^ par_q) != cfg_par_typ) && !brk_f;
    ok_f        = !(brk_f || par_bad_f || stop_bad_f);
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_LINE_WAIT: if (RX_IN) next_state = S_IDLE;
      S_IDLE:      if (!RX_IN) next_state = S_START;
      S_START: begin
        if (at_m_hi && maj_now) next_state = S_IDLE;
        else if (end_bit)       next_state = S_DATA;
      end
      S_DATA:   if (end_bit && last_data) next_state = cfg_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (end_bit) next_state = S_STOP;
      S_STOP:   if (end_bit && last_stop) next_state = S_CHECK;
      S_CHECK: begin
        if (BRK_DET)     next_state = S_LINE_WAIT;
        else if (!RX_IN) next_state = S_START;
        else             next_state = S_IDLE;
      end
      default: next_state = S_LINE_WAIT;
    endcase
    enter_start = (next_state == S_START) && (state != S_START);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_LINE_WAIT;
    else     state <= next_state;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      samp        <= '0;
      bit_q       <= 1'b0;
      cfg_p       <= '0;
      cfg_par_en  <= 1'b0;
      cfg_par_typ <= 1'b0;
      cfg_dlen    <= '0;
      cfg_stp2    <= 1'b0;
      shift_r     <= '0;
      par_q       <= 1'b0;
      stop1_q     <= 1'b0;
      stop_bad_q  <= 1'b0;
      P_DATA      <= '0;
      DATA_VALID  <= 1'b0;
      PAR_ERR     <= 1'b0;
      STP_ERR     <= 1'b0;
      BRK_DET     <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      BRK_DET    <= 1'b0;
      BUSY       <= (next_state != S_IDLE);

      if (in_bit && (next_state == state) && !end_bit) edge_cnt <= edge_cnt + ONE_P;
      else                                             edge_cnt <= '0;

      if (next_state != state)  bit_cnt <= '0;
      else if (in_bit && end_bit) bit_cnt <= bit_cnt + ONE_B;

      if (in_bit && (at_m_lo || at_m)) samp  <= {samp[0], RX_IN};
      if (in_bit && at_m_hi)           bit_q <= maj_now;

      if (enter_start) begin
        cfg_p       <= Prescale;
        cfg_par_en  <= PAR_EN;
        cfg_par_typ <= PAR_TYP;
        cfg_dlen    <= DATA_LEN;
        cfg_stp2    <= STP2;
        shift_r     <= '0;
        par_q       <= 1'b0;
        stop1_q     <= 1'b1;
        stop_bad_q  <= 1'b0;
      end else if (end_bit) begin
        case (state)
          S_DATA:   shift_r <= {bit_now, shift_r[MAX_DATA_WIDTH-1:1]};
          S_PARITY: par_q   <= bit_now;
          S_STOP: begin
            stop1_q    <= stop1_f;
            stop_bad_q <= stop_bad_f;
          end
          default: ;
        endcase
      end

      // Flags are registered so they are high exactly while the FSM sits in CHECK.
      if (state == S_STOP && next_state == S_CHECK) begin
        DATA_VALID <= ok_f;
        PAR_ERR    <= par_bad_f;
        STP_ERR    <= stop_bad_f;
        BRK_DET    <= brk_f;
        if (ok_f) P_DATA <= data_rj;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed and randomized frames for uart_rx_frame_ctrl, checked against a
// frame-level reference model (expected pulse cycle, flags and P_DATA).
module tb_uart_rx_frame_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] DATA_LEN;
  logic       STP2;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR, BRK_DET, BUSY;

  typedef struct {
    int         c;
    logic       dv, pe, se, bd;
    logic [7:0] pd;
  } ev_t;

  ev_t        ev_q[$];
  ev_t        exp_q[$];
  ev_t        mon_e;
  ev_t        brk_e;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         c0;
  logic [7:0] model_pd;

  uart_rx_frame_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .DATA_LEN(DATA_LEN), .STP2(STP2), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
    .BRK_DET(BRK_DET), .BUSY(BUSY)
  );

  // clock / reset-independent cycle stamp
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (DATA_VALID || PAR_ERR || STP_ERR || BRK_DET) begin
      mon_e.c  = cyc;
      mon_e.dv = DATA_VALID;
      mon_e.pe = PAR_ERR;
      mon_e.se = STP_ERR;
      mon_e.bd = BRK_DET;
      mon_e.pd = P_DATA;
      ev_q.push_back(mon_e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_cfg(input logic [5:0] p, input logic pen, input logic ptyp,
                         input logic [1:0] dlen, input logic stp2);
    Prescale = p;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    DATA_LEN = dlen;
    STP2     = stp2;
  endtask

  // Drives one frame bit by bit at negedges; b2b means the DUT sits in CHECK
  // when the start bit begins, so its frame reference is one cycle later.
  task automatic send_frame(input logic [7:0] d, input logic flip, input logic s1,
                            input logic s2, input int gap, input bit b2b);
    int         n, p, c;
    logic [7:0] dm;
    logic       pb;
    logic       bits[$];
    ev_t        e;
    n  = 5 + int'(DATA_LEN);
    p  = int'(Prescale);
    dm = d & 8'((1 << n) - 1);
    pb = PAR_TYP ^ (^dm) ^ flip;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) bits.push_back(dm[i]);
    if (PAR_EN) bits.push_back(pb);
    bits.push_back(s1);
    if (STP2) bits.push_back(s2);
    e.bd = (dm == 8'h00) && !(PAR_EN && pb) && !s1;
    e.se = !s1 || (STP2 && !s2);
    e.pe = PAR_EN && !e.bd && ((^dm ^ pb) != PAR_TYP);
    e.dv = !(e.bd || e.se || e.pe);
    if (e.dv) model_pd = dm;
    e.pd = model_pd;
    c = -1;
    foreach (bits[k]) begin
      for (int j = 0; j < p; j++) begin
        @(negedge CLK);
        RX_IN = bits[k];
        if (c < 0) c = cyc;
      end
    end
    e.c = (b2b ? c + 1 : c) + 1 + p * bits.size();
    exp_q.push_back(e);
    repeat (gap) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    ev_t o, x;
    repeat (4) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
    chk({tag, "_count"}, ev_q.size(), exp_q.size());
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      o = ev_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, "_cyc"}, o.c, x.c);
      chk({tag, "_dv"}, o.dv, x.dv);
      chk({tag, "_pe"}, o.pe, x.pe);
      chk({tag, "_se"}, o.se, x.se);
      chk({tag, "_bd"}, o.bd, x.bd);
      chk({tag, "_pd"}, o.pd, x.pd);
    end
    ev_q.delete();
    exp_q.delete();
    chk({tag, "_pdata_hold"}, P_DATA, model_pd);
  endtask

  initial begin
    RST   = 1'b1;
    RX_IN = 1'b1;
    model_pd = 8'h00;
    set_cfg(6'd8, 1'b0, 1'b0, 2'b11, 1'b0);
    repeat (3) @(negedge CLK);
    chk("rst_pdata", P_DATA, 8'h00);
    chk("rst_dv", DATA_VALID, 1'b0);
    chk("rst_pe", PAR_ERR, 1'b0);
    chk("rst_se", STP_ERR, 1'b0);
    chk("rst_bd", BRK_DET, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("idle_busy", BUSY, 1'b0);

    // 8N1 0xA5 at P=8
    set_cfg(6'd8, 1'b0, 1'b0, 2'b11, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 6, 1'b0);
    drain("t1");

    // 7E2 0x35 at P=16, then a parity-flipped copy
    set_cfg(6'd16, 1'b1, 1'b0, 2'b10, 1'b1);
    send_frame(8'h35, 1'b0, 1'b1, 1'b1, 6, 1'b0);
    drain("t2_ok");
    send_frame(8'h35, 1'b1, 1'b1, 1'b1, 6, 1'b0);
    drain("t2_par");

    // 5O2 with the second stop bit low
    set_cfg(6'd8, 1'b1, 1'b1, 2'b00, 1'b1);
    send_frame(8'h1F, 1'b0, 1'b1, 1'b0, 6, 1'b0);
    drain("t3_stp");

    // one-cycle low glitch in 5O1
    set_cfg(6'd8, 1'b1, 1'b1, 2'b00, 1'b0);
    @(negedge CLK); RX_IN = 1'b0;
    @(negedge CLK); RX_IN = 1'b1;
    chk("glitch_busy", BUSY, 1'b1);
    repeat (10) @(negedge CLK);
    chk("glitch_idle", BUSY, 1'b0);
    drain("t3_glitch");

    // break: 8E1 line held low 200 cycles
    set_cfg(6'd8, 1'b1, 1'b0, 2'b11, 1'b0);
    c0 = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge CLK);
      RX_IN = 1'b0;
      if (j == 0) c0 = cyc;
      if (j == 150) chk("brk_busy_low", BUSY, 1'b1);
    end
    brk_e.c  = c0 + 1 + 8 * (1 + 8 + 1 + 1);
    brk_e.dv = 1'b0;
    brk_e.pe = 1'b0;
    brk_e.se = 1'b1;
    brk_e.bd = 1'b1;
    brk_e.pd = model_pd;
    exp_q.push_back(brk_e);
    @(negedge CLK); RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("brk_busy_high", BUSY, 1'b0);
    drain("t4");

    // back-to-back 8N1 frames with no idle gap
    set_cfg(6'd8, 1'b0, 1'b0, 2'b11, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 6, 1'b1);
    drain("t5");

    // randomized formats, data and error injection
    for (int r = 0; r < 16; r++) begin
      set_cfg(6'($urandom_range(8, 24)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 7) != 0), int'($urandom_range(3, 9)), 1'b0);
      drain("rnd");
    end

    // async reset during data bit 4 of an 8N1 frame of 0x3C
    set_cfg(6'd8, 1'b0, 1'b0, 2'b11, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 8; j++) begin
        @(negedge CLK);
        RX_IN = (k == 0) ? 1'b0 : ((8'h3C >> (k - 1)) & 8'h01) != 8'h00;
      end
    end
    repeat (4) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midrst_pdata", P_DATA, 8'h00);
    chk("midrst_flags", {DATA_VALID, PAR_ERR, STP_ERR, BRK_DET}, 4'b0000);
    chk("midrst_busy", BUSY, 1'b0);
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_pd = 8'h00;
    repeat (20) begin
      @(negedge CLK);
      RX_IN = 1'b0;
    end
    chk("rst_low_busy", BUSY, 1'b1);
    drain("t6_wait");
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 6, 1'b0);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
